// File: rtl/alu_activity_monitor.sv
// alu_activity_monitor: counts bit toggles on ALU X/Y/Z buses and flags over a
// fixed window of samples and hands the totals out through a valid/ready handshake.
module alu_activity_monitor #(
    parameter int DW     = 16,
    parameter int FW     = 5,
    parameter int WINDOW = 256,
    parameter int CW     = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          sample_en,
    input  logic [DW-1:0] x_in,
    input  logic [DW-1:0] y_in,
    input  logic [DW-1:0] z_in,
    input  logic [FW-1:0] flags_in,
    output logic          busy,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] tog_x,
    output logic [CW-1:0] tog_y,
    output logic [CW-1:0] tog_z,
    output logic [CW-1:0] tog_f,
    output logic [CW-1:0] tog_total,
    output logic          sat
);
    localparam int NW = $clog2(WINDOW + 1);
    typedef enum logic [1:0] {IDLE, PRIME, COUNT, DONE} state_t;
    state_t state_q, state_d;
    logic [DW-1:0] prev_x_q, prev_y_q, prev_z_q;
    logic [FW-1:0] prev_f_q;
    logic [CW-1:0] acc_x_q, acc_y_q, acc_z_q, acc_f_q, acc_t_q;
    logic [CW-1:0] acc_x_d, acc_y_d, acc_z_d, acc_f_d, acc_t_d;
    logic [CW-1:0] px, py, pz, pf, pt;
    logic          ox, oy, oz, of, ot, sat_q, sat_d;
    logic [NW-1:0] cnt_q;
    logic          last, go, prime_en, count_en;

    function automatic logic [CW-1:0] pc(input logic [DW-1:0] v);
        pc = '0;
        for (int i = 0; i < DW; i++) pc += CW'(v[i]);
    endfunction

    // Returns {overflow, sum}; the sum clamps to all-ones on overflow.
    function automatic logic [CW:0] sadd(input logic [CW-1:0] a, input logic [CW-1:0] b);
        logic [CW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CW] ? {1'b1, {CW{1'b1}}} : s;
    endfunction

    always_comb begin
        px = pc(x_in ^ prev_x_q);
        py = pc(y_in ^ prev_y_q);
        pz = pc(z_in ^ prev_z_q);
        pf = pc(DW'(flags_in ^ prev_f_q));
        pt = px + py + pz + pf;
        {ox, acc_x_d} = sadd(acc_x_q, px);
        {oy, acc_y_d} = sadd(acc_y_q, py);
        {oz, acc_z_d} = sadd(acc_z_q, pz);
        {of, acc_f_d} = sadd(acc_f_q, pf);
        {ot, acc_t_d} = sadd(acc_t_q, pt);
        sat_d    = sat_q | ox | oy | oz | of | ot;
        last     = cnt_q == NW'(WINDOW - 1);
        go       = state_q == IDLE && start && !abort;
        prime_en = state_q == PRIME && sample_en && !abort;
        count_en = state_q == COUNT && sample_en && !abort;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  state_d = go ? PRIME : IDLE;
            PRIME: state_d = abort ? IDLE : sample_en ? COUNT : PRIME;
            COUNT: state_d = abort ? IDLE : (sample_en && last) ? DONE : COUNT;
            DONE:  state_d = res_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = state_q == PRIME || state_q == COUNT;
        res_valid = state_q == DONE;
        sat       = sat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {prev_x_q, prev_y_q, prev_z_q, prev_f_q} <= '0;
            {acc_x_q, acc_y_q, acc_z_q, acc_f_q, acc_t_q} <= '0;
            {tog_x, tog_y, tog_z, tog_f, tog_total} <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            if (go) begin
                {acc_x_q, acc_y_q, acc_z_q, acc_f_q, acc_t_q} <= '0;
                cnt_q <= '0;
                sat_q <= 1'b0;
            end
            if (prime_en || count_en) {prev_x_q, prev_y_q, prev_z_q, prev_f_q} <= {x_in, y_in, z_in, flags_in};
            if (count_en) begin
                {acc_x_q, acc_y_q, acc_z_q, acc_f_q, acc_t_q} <= {acc_x_d, acc_y_d, acc_z_d, acc_f_d, acc_t_d};
                sat_q <= sat_d;
                cnt_q <= cnt_q + 1'b1;
                if (last) {tog_x, tog_y, tog_z, tog_f, tog_total} <= {acc_x_d, acc_y_d, acc_z_d, acc_f_d, acc_t_d};
            end
        end
    end
endmodule

// File: tb/tb_alu_activity_monitor.sv
// tb_alu_activity_monitor: directed checks on four monitor instances of different
// window/width settings that share one set of input drivers.
module tb_alu_activity_monitor;
    logic clk = 0, rst_n = 0, start = 0, abort = 0, sample_en = 0, res_ready = 0;
    logic [15:0] x_in = 0, y_in = 0, z_in = 0;
    logic [4:0] flags_in = 0;
    int total = 0, pass = 0;

    logic a_busy, a_rv, a_sat, b_busy, b_rv, b_sat, c_busy, c_rv, c_sat, d_busy, d_rv, d_sat;
    logic [23:0] a_x, a_y, a_z, a_f, a_t, c_x, c_y, c_z, c_f, c_t, d_x, d_y, d_z, d_f, d_t;
    logic [5:0] b_x, b_y, b_z, b_f, b_t;

    always #5 clk = ~clk;

    alu_activity_monitor #(.WINDOW(2)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sample_en(sample_en),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .flags_in(flags_in), .busy(a_busy),
        .res_valid(a_rv), .res_ready(res_ready), .tog_x(a_x), .tog_y(a_y), .tog_z(a_z),
        .tog_f(a_f), .tog_total(a_t), .sat(a_sat));
    alu_activity_monitor #(.WINDOW(4), .CW(6)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sample_en(sample_en),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .flags_in(flags_in), .busy(b_busy),
        .res_valid(b_rv), .res_ready(res_ready), .tog_x(b_x), .tog_y(b_y), .tog_z(b_z),
        .tog_f(b_f), .tog_total(b_t), .sat(b_sat));
    alu_activity_monitor #(.WINDOW(3)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sample_en(sample_en),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .flags_in(flags_in), .busy(c_busy),
        .res_valid(c_rv), .res_ready(res_ready), .tog_x(c_x), .tog_y(c_y), .tog_z(c_z),
        .tog_f(c_f), .tog_total(c_t), .sat(c_sat));
    alu_activity_monitor u_d (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .sample_en(sample_en),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .flags_in(flags_in), .busy(d_busy),
        .res_valid(d_rv), .res_ready(res_ready), .tog_x(d_x), .tog_y(d_y), .tog_z(d_z),
        .tog_f(d_f), .tog_total(d_t), .sat(d_sat));

    // One clock: drive at negedge, strobes drop 1ns after the rising edge.
    task automatic cyc(input logic en, input logic [15:0] x, input logic [15:0] y,
                       input logic [15:0] z, input logic [4:0] f, input logic st, input logic ab);
        @(negedge clk);
        sample_en = en; x_in = x; y_in = y; z_in = z; flags_in = f; start = st; abort = ab;
        @(posedge clk);
        #1;
        sample_en = 0; start = 0; abort = 0;
    endtask

    task automatic samp(input logic [15:0] x, input logic [15:0] y, input logic [4:0] f);
        cyc(1, x, y, 16'h0, f, 0, 0);
    endtask

    task automatic go();
        cyc(0, 16'h0, 16'h0, 16'h0, 5'h0, 1, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; res_ready = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        total++; if ({a_busy, a_rv, a_sat} !== 3'b000) $display("FAIL reset_ctl got %b exp 000", {a_busy, a_rv, a_sat}); else pass++;
        total++; if ({a_x, a_y, a_z, a_f, a_t} !== '0) $display("FAIL reset_tog got %h exp 0", {a_x, a_y, a_z, a_f, a_t}); else pass++;
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_basic();
        do_reset();
        go();
        total++; if (a_busy !== 1) $display("FAIL t1_busy got %b exp 1", a_busy); else pass++;
        samp(16'h4F86, 16'h1238, 0);
        samp(16'h4F85, 16'h8000, 0);
        total++; if (a_rv !== 0) $display("FAIL t1_early_valid got %b exp 0", a_rv); else pass++;
        samp(16'hAAAA, 16'h5557, 0);
        total++; if (a_rv !== 1) $display("FAIL t1_valid got %b exp 1", a_rv); else pass++;
        total++; if (a_x !== 24'd12) $display("FAIL t1_tog_x got %0d exp 12", a_x); else pass++;
        total++; if (a_y !== 24'd16) $display("FAIL t1_tog_y got %0d exp 16", a_y); else pass++;
        total++; if ({a_z, a_f} !== '0) $display("FAIL t1_tog_zf got %0d exp 0", {a_z, a_f}); else pass++;
        total++; if (a_t !== 24'd28) $display("FAIL t1_total got %0d exp 28", a_t); else pass++;
        res_ready = 1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        res_ready = 0;
        total++; if (a_rv !== 0) $display("FAIL t1_accept got %b exp 0", a_rv); else pass++;
    endtask

    task automatic test_gaps();
        do_reset();
        go();
        samp(16'h4F86, 16'h1238, 0);
        cyc(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5'h1F, 0, 0);
        samp(16'h4F85, 16'h8000, 0);
        cyc(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5'h1F, 0, 0);
        cyc(0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 5'h1F, 0, 0);
        samp(16'hAAAA, 16'h5557, 0);
        total++; if (a_rv !== 1) $display("FAIL t2_valid got %b exp 1", a_rv); else pass++;
        total++; if ({a_x, a_y, a_z, a_f, a_t} !== {24'd12, 24'd16, 24'd0, 24'd0, 24'd28})
            $display("FAIL t2_tog got %0d/%0d/%0d/%0d/%0d exp 12/16/0/0/28", a_x, a_y, a_z, a_f, a_t); else pass++;
    endtask

    task automatic test_backpressure();
        logic bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            cyc(0, 16'h1234, 16'h5678, 16'h9ABC, 5'h15, i == 5, 0);
            if (a_rv !== 1 || a_busy !== 0 || a_x !== 24'd12 || a_t !== 24'd28) bad = 1;
        end
        total++; if (bad !== 0) $display("FAIL t3_hold got %b exp 0", bad); else pass++;
        res_ready = 1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        res_ready = 0;
        total++; if (a_rv !== 0) $display("FAIL t3_release got %b exp 0", a_rv); else pass++;
        cyc(0, 0, 0, 0, 0, 0, 0);
        total++; if (a_busy !== 0) $display("FAIL t3_start_ignored got %b exp 0", a_busy); else pass++;
        total++; if (a_y !== 24'd16) $display("FAIL t3_result_hold got %0d exp 16", a_y); else pass++;
    endtask

    task automatic test_saturation();
        do_reset();
        go();
        for (int i = 0; i < 5; i++) samp(i % 2 ? 16'hFFFF : 16'h0000, 0, 0);
        total++; if (b_rv !== 1) $display("FAIL t4_valid got %b exp 1", b_rv); else pass++;
        total++; if (b_x !== 6'd63) $display("FAIL t4_tog_x got %0d exp 63", b_x); else pass++;
        total++; if (b_t !== 6'd63) $display("FAIL t4_total got %0d exp 63", b_t); else pass++;
        total++; if (b_sat !== 1) $display("FAIL t4_sat got %b exp 1", b_sat); else pass++;
        res_ready = 1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        res_ready = 0;
        total++; if (b_sat !== 1) $display("FAIL t4_sat_sticky got %b exp 1", b_sat); else pass++;
        go();
        total++; if ({b_sat, b_busy} !== 2'b01) $display("FAIL t4_sat_clear got %b exp 01", {b_sat, b_busy}); else pass++;
    endtask

    task automatic test_flags();
        do_reset();
        go();
        samp(0, 0, 5'b00000);
        samp(0, 0, 5'b11111);
        samp(0, 0, 5'b00000);
        samp(0, 0, 5'b10101);
        total++; if (c_rv !== 1) $display("FAIL t6_valid got %b exp 1", c_rv); else pass++;
        total++; if (c_f !== 24'd13) $display("FAIL t6_tog_f got %0d exp 13", c_f); else pass++;
        total++; if (c_t !== 24'd13) $display("FAIL t6_total got %0d exp 13", c_t); else pass++;
        total++; if (c_x !== 24'd0) $display("FAIL t6_tog_x got %0d exp 0", c_x); else pass++;
    endtask

    task automatic test_abort();
        logic seen;
        do_reset();
        go();
        for (int i = 0; i < 4; i++) samp(i % 2 ? 16'hFFFF : 16'h0000, 0, 0);
        total++; if (d_busy !== 1) $display("FAIL t5_busy got %b exp 1", d_busy); else pass++;
        cyc(0, 0, 0, 0, 0, 0, 1);
        total++; if (d_busy !== 0) $display("FAIL t5_abort_busy got %b exp 0", d_busy); else pass++;
        seen = 0;
        res_ready = 0;
        for (int i = 0; i < 260; i++) begin
            samp(i % 2 ? 16'hFFFF : 16'h0000, 0, 0);
            if (d_rv !== 0) seen = 1;
        end
        total++; if (seen !== 0) $display("FAIL t5_no_valid got %b exp 0", seen); else pass++;
        cyc(0, 0, 0, 0, 0, 1, 1);
        total++; if (d_busy !== 0) $display("FAIL start_abort_idle got %b exp 0", d_busy); else pass++;
    endtask

    task automatic test_abort_end_of_window();
        do_reset();
        go();
        samp(16'h0000, 0, 0);
        samp(16'hFFFF, 0, 0);
        cyc(1, 16'h0000, 0, 0, 0, 0, 1);
        total++; if ({a_busy, a_rv} !== 2'b00) $display("FAIL eow_abort got %b exp 00", {a_busy, a_rv}); else pass++;
        total++; if (a_x !== 24'd0) $display("FAIL eow_abort_tog got %0d exp 0", a_x); else pass++;
    endtask

    task automatic test_full_window_and_reset();
        do_reset();
        go();
        for (int i = 0; i < 257; i++) samp(i % 2 ? 16'hFFFF : 16'h0000, 0, 0);
        total++; if (d_rv !== 1) $display("FAIL w256_valid got %b exp 1", d_rv); else pass++;
        total++; if (d_x !== 24'd4096 || d_t !== 24'd4096) $display("FAIL w256_tog got %0d/%0d exp 4096/4096", d_x, d_t); else pass++;
        res_ready = 1;
        cyc(0, 0, 0, 0, 0, 0, 0);
        res_ready = 0;
        go();
        for (int i = 0; i < 5; i++) samp(i % 2 ? 16'hFFFF : 16'h0000, 16'h00FF, 0);
        #3;
        rst_n = 0;
        #1;
        total++; if ({d_busy, d_rv, d_sat} !== 3'b000) $display("FAIL t5_rst_ctl got %b exp 000", {d_busy, d_rv, d_sat}); else pass++;
        total++; if ({d_x, d_y, d_z, d_f, d_t} !== '0) $display("FAIL t5_rst_tog got %h exp 0", {d_x, d_y, d_z, d_f, d_t}); else pass++;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_backpressure();
        test_saturation();
        test_flags();
        test_abort();
        test_abort_end_of_window();
        test_full_window_and_reset();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
